// File: rtl/dmem_ctrl.sv
// Memory-stage data-memory controller: turns M-stage load/store requests into
// word-addressed req/ack bus transactions, stalling the pipeline until done.
module dmem_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [1:0]  InstrM_2b,
  output logic [31:0] MemDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        MemFaultM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam logic [1:0]  IDLE = 2'd0;
  localparam logic [1:0]  BUSY = 2'd1;
  localparam logic [1:0]  DONE = 2'd2;
  localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mem_q, mem_d;
  logic        mis_q, mis_d;
  logic        fault_q, fault_d;

  logic        req;
  logic        is_half;
  logic        is_word;
  logic        misalign;
  logic        timeout_hit;
  logic [3:0]  be;
  logic [31:0] wdata;

  // Access decode: size 11 behaves as a word.
  always_comb begin
    req      = MemReadM | MemWriteM;
    is_half  = (InstrM_2b == 2'b01);
    is_word  = InstrM_2b[1];
    misalign = (is_half & ALUResultM[0]) | (is_word & (|ALUResultM[1:0]));
    if (is_word) begin
      be    = 4'b1111;
      wdata = WriteDataM;
    end else if (is_half) begin
      be    = 4'b0011 << {ALUResultM[1], 1'b0};
      wdata = {2{WriteDataM[15:0]}};
    end else begin
      be    = 4'b0001 << ALUResultM[1:0];
      wdata = {4{WriteDataM[7:0]}};
    end
    timeout_hit = (TO_LIMIT != 32'd0) && (cnt_q == TO_LIMIT - 32'd1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    mem_d   = mem_q;
    mis_d   = 1'b0;
    fault_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (misalign) begin
            mis_d = 1'b1;
          end else begin
            we_d    = MemWriteM;
            addr_d  = {ALUResultM[31:2], 2'b00};
            be_d    = be;
            wdata_d = wdata;
            req_d   = 1'b1;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // An ack arriving on the timeout cycle still completes normally.
        if (bus_ack) begin
          req_d   = 1'b0;
          if (!we_q) mem_d = bus_rdata;
          state_d = DONE;
        end else if (timeout_hit) begin
          req_d   = 1'b0;
          mem_d   = 32'd0;
          fault_d = 1'b1;
          state_d = DONE;
        end else if (TO_LIMIT != 32'd0) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DONE: begin
        cnt_d   = 32'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      mem_q   <= 32'd0;
      mis_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      mem_q   <= mem_d;
      mis_q   <= mis_d;
      fault_q <= fault_d;
    end
  end

  assign StallM    = ((state_q == IDLE) && req && !misalign) || (state_q == BUSY);
  assign MemDataM  = mem_q;
  assign MisalignM = mis_q;
  assign MemFaultM = fault_q;
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed vector table, reset/back-to-back sequences,
// and random transactions checked against a transaction-level model.
module tb_dmem_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [1:0]  InstrM_2b;
  logic [31:0] MemDataM;
  logic        StallM, MisalignM, MemFaultM;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  dmem_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .InstrM_2b(InstrM_2b),
    .MemDataM(MemDataM), .StallM(StallM), .MisalignM(MisalignM), .MemFaultM(MemFaultM),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr;
    logic [1:0]  sz;
    logic [31:0] wd, rdata;
    int          k;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_we, e_mis, e_fault;
    logic [31:0] e_mem;
    int          e_stall;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_mem = 32'd0;
  vec_t        tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [1:0] sz, input logic [31:0] wd, input logic [31:0] rdata,
                              input int k, input logic [31:0] e_addr, input logic [3:0] e_be,
                              input logic [31:0] e_wdata, input logic e_mis, input logic e_fault,
                              input logic [31:0] e_mem, input int e_stall);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.sz = sz; v.wd = wd; v.rdata = rdata; v.k = k;
    v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata; v.e_we = wr;
    v.e_mis = e_mis; v.e_fault = e_fault; v.e_mem = e_mem; v.e_stall = e_stall;
    return v;
  endfunction

  // Transaction-level reference: expectations from access size and address arithmetic.
  function automatic vec_t rand_vec(input logic [31:0] prev_mem);
    vec_t v;
    int   a, bytes;
    v.wr = 1'($urandom_range(0, 1));
    v.rd = 1'($urandom_range(0, 1));
    if (!v.wr && !v.rd) v.rd = 1'b1;
    v.sz = 2'($urandom_range(0, 3));
    v.addr = $urandom; v.wd = $urandom; v.rdata = $urandom;
    v.k = $urandom_range(0, 6);
    a = int'(v.addr % 32'd4);
    bytes = (v.sz == 2'd0) ? 1 : (v.sz == 2'd1) ? 2 : 4;
    v.e_mis = (a % bytes) != 0;
    v.e_addr = v.addr - 32'(a);
    v.e_be = 4'(((1 << bytes) - 1) << a);
    if (bytes == 1)      v.e_wdata = (v.wd & 32'hFF) * 32'h01010101;
    else if (bytes == 2) v.e_wdata = (v.wd & 32'hFFFF) * 32'h00010001;
    else                 v.e_wdata = v.wd;
    v.e_we = v.wr;
    v.e_fault = 1'b0;
    if (v.e_mis) begin
      v.e_mem = prev_mem; v.e_stall = 0;
    end else if (v.k < TO) begin
      v.e_mem = v.wr ? prev_mem : v.rdata; v.e_stall = 2 + v.k;
    end else begin
      v.e_mem = 32'd0; v.e_fault = 1'b1; v.e_stall = 1 + TO;
    end
    return v;
  endfunction

  task automatic access(input vec_t v);
    int stalls;
    @(posedge clk); #1;
    MemReadM = v.rd; MemWriteM = v.wr; ALUResultM = v.addr; InstrM_2b = v.sz;
    WriteDataM = v.wd; bus_ack = 1'b0;
    @(negedge clk);
    chk("stall_issue", StallM, !v.e_mis);
    chk("req_idle", bus_req, 1'b0);
    chk("mem_prev", MemDataM, exp_mem);
    stalls = StallM ? 1 : 0;
    if (v.e_mis) begin
      @(posedge clk); #1;
      MemReadM = 1'b0; MemWriteM = 1'b0;
      @(negedge clk);
      chk("misalign_pulse", MisalignM, 1'b1);
      chk("mis_no_req", bus_req, 1'b0);
      chk("mis_no_stall", StallM, 1'b0);
      chk("mis_mem", MemDataM, v.e_mem);
      @(posedge clk); #1;
      @(negedge clk);
      chk("misalign_clear", MisalignM, 1'b0);
      chk("mis_no_req2", bus_req, 1'b0);
    end else begin
      for (int i = 0; i < 64; i++) begin
        @(posedge clk); #1;
        bus_ack = (i == v.k);
        bus_rdata = (i == v.k) ? v.rdata : $urandom;
        @(negedge clk);
        chk("busy_req", bus_req, 1'b1);
        chk("busy_stall", StallM, 1'b1);
        chk("bus_we", bus_we, v.e_we);
        chk("bus_addr", bus_addr, v.e_addr);
        chk("bus_be", bus_be, v.e_be);
        chk("bus_wdata", bus_wdata, v.e_wdata);
        stalls++;
        if (i == v.k || i + 1 == TO) break;
      end
      // Stray ack during DONE must be ignored.
      @(posedge clk); #1;
      bus_ack = 1'b1; bus_rdata = ~v.e_mem;
      @(negedge clk);
      chk("done_stall", StallM, 1'b0);
      chk("done_req", bus_req, 1'b0);
      chk("done_mem", MemDataM, v.e_mem);
      chk("done_fault", MemFaultM, v.e_fault);
      chk("done_misalign", MisalignM, 1'b0);
    end
    chk("stall_cycles", 32'(stalls), 32'(v.e_stall));
    exp_mem = v.e_mem;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    MemReadM = 1'b0; MemWriteM = 1'b0; bus_ack = 1'b0;
    @(negedge clk);
    chk("idle_stall", StallM, 1'b0);
    chk("idle_req", bus_req, 1'b0);
    chk("idle_fault", MemFaultM, 1'b0);
    chk("idle_mem", MemDataM, exp_mem);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(0, 1, 32'h100, 2'd2, 32'hDEADBEEF, 32'h0,        2, 32'h100, 4'hF, 32'hDEADBEEF, 0, 0, 32'h0,        4);
    tbl[1] = mk(1, 0, 32'h103, 2'd0, 32'h000000A5, 32'h11223344, 0, 32'h100, 4'h8, 32'hA5A5A5A5, 0, 0, 32'h11223344, 2);
    tbl[2] = mk(0, 1, 32'h102, 2'd1, 32'h0000ABCD, 32'h0,        1, 32'h100, 4'hC, 32'hABCDABCD, 0, 0, 32'h11223344, 3);
    tbl[3] = mk(1, 0, 32'h101, 2'd1, 32'h0,        32'h0,        0, 32'h0,   4'h0, 32'h0,        1, 0, 32'h11223344, 0);
    tbl[4] = mk(1, 0, 32'h102, 2'd2, 32'h0,        32'h0,        0, 32'h0,   4'h0, 32'h0,        1, 0, 32'h11223344, 0);
    tbl[5] = mk(1, 0, 32'h8,   2'd3, 32'h0,        32'h55AA55AA, 3, 32'h8,   4'hF, 32'h0,        0, 0, 32'h55AA55AA, 5);
    tbl[6] = mk(1, 1, 32'h41,  2'd0, 32'h12345677, 32'hFFFFFFFF, 0, 32'h40,  4'h2, 32'h77777777, 0, 0, 32'h55AA55AA, 2);
    tbl[7] = mk(1, 0, 32'h20,  2'd2, 32'h0,        32'h0,        9, 32'h20,  4'hF, 32'h0,        0, 1, 32'h0,        5);
    tbl[8] = mk(1, 0, 32'h2,   2'd1, 32'h0000BEEF, 32'hCAFEF00D, 1, 32'h0,   4'hC, 32'hBEEFBEEF, 0, 0, 32'hCAFEF00D, 3);

    reset = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; ALUResultM = 32'h0;
    WriteDataM = 32'h0; InstrM_2b = 2'd0; bus_rdata = 32'h0; bus_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", StallM, 1'b0);
    chk("rst_misalign", MisalignM, 1'b0);
    chk("rst_fault", MemFaultM, 1'b0);
    chk("rst_req", bus_req, 1'b0);
    chk("rst_we", bus_we, 1'b0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_be", bus_be, 4'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_mem", MemDataM, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int t = 0; t < 9; t++) begin
      access(tbl[t]);
      idle_cycle();
    end

    // Back-to-back loads: second request presented right after DONE.
    access(mk(1, 0, 32'h0, 2'd2, 32'h0, 32'h000000A1, 1, 32'h0, 4'hF, 32'h0, 0, 0, 32'h000000A1, 3));
    access(mk(1, 0, 32'h4, 2'd2, 32'h0, 32'h000000B2, 0, 32'h4, 4'hF, 32'h0, 0, 0, 32'h000000B2, 2));
    idle_cycle();

    // Reset during the second BUSY cycle, followed by a late ack.
    @(posedge clk); #1;
    MemReadM = 1'b1; ALUResultM = 32'h200; InstrM_2b = 2'd2; bus_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rb_req", bus_req, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; MemReadM = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h99999999;
    @(negedge clk);
    chk("rb_req_drop", bus_req, 1'b0);
    chk("rb_stall", StallM, 1'b0);
    chk("rb_mem", MemDataM, 32'h0);
    chk("rb_addr", bus_addr, 32'h0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    chk("rb_late_ack_mem", MemDataM, 32'h0);
    chk("rb_late_ack_req", bus_req, 1'b0);
    exp_mem = 32'h0;

    for (int r = 0; r < 40; r++) begin
      access(rand_vec(exp_mem));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
